// File: rtl/spu_sm_exp_sum_reci_if.sv
// Handshake bundle between the exp unit, the exp-sum/reciprocal stage and the normalise stage.
// The master side drives rows and exp values; the slave side returns the reciprocal.
interface spu_sm_exp_sum_reci_if #(
    parameter int DIN_W  = 8,
    parameter int LEN_W  = 10,
    parameter int SUM_W  = 18,
    parameter int RECI_W = 16
) ();
    logic              start;
    logic [LEN_W-1:0]  row_len;
    logic              din_valid;
    logic [DIN_W-1:0]  din_q;
    logic              din_ready;
    logic              busy;
    logic [SUM_W-1:0]  sum_q;
    logic              reci_valid;
    logic              reci_ready;
    logic [RECI_W-1:0] reci_q;
    logic              reci_sat;
    logic              div_zero;

    modport master (
        output start, row_len, din_valid, din_q, reci_ready,
        input  din_ready, busy, sum_q, reci_valid, reci_q, reci_sat, div_zero
    );

    modport slave (
        input  start, row_len, din_valid, din_q, reci_ready,
        output din_ready, busy, sum_q, reci_valid, reci_q, reci_sat, div_zero
    );
endinterface

// File: rtl/spu_sm_exp_sum_reci.sv
// Softmax row stage: sums the exp values of one row, then forms the saturated reciprocal
// 2^RECI_SHIFT / sum with a bit-serial restoring divider (one quotient bit per clock).
module spu_sm_exp_sum_reci #(
    parameter int DIN_W      = 8,
    parameter int LEN_W      = 10,
    parameter int SUM_W      = 18,
    parameter int RECI_SHIFT = 24,
    parameter int RECI_W     = 16
) (
    input  logic                  core_clk,
    input  logic                  rst,
    spu_sm_exp_sum_reci_if.slave  bus
);
    localparam int CNT_W = $clog2(RECI_SHIFT + 1);
    localparam int REM_W = SUM_W + 1;
    localparam int QUO_W = RECI_SHIFT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [LEN_W-1:0]  row_len_r;
    logic [LEN_W-1:0]  elem_cnt_r;
    logic [SUM_W-1:0]  sum_r;
    logic [REM_W-1:0]  rem_r;
    logic [QUO_W-1:0]  quo_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [RECI_W-1:0] reci_r;
    logic              sat_r;
    logic              zero_r;

    logic              accept_s;
    logic              last_s;
    logic              num_bit_s;
    logic [REM_W-1:0]  rem_shift_s;
    logic              q_bit_s;
    logic [REM_W-1:0]  rem_next_s;
    logic [QUO_W-1:0]  quo_next_s;
    logic              quo_ovf_s;

    // Handshake qualifiers for the accumulate phase
    always_comb begin
        accept_s = (state_r == ACC) && bus.din_valid;
        last_s   = accept_s && (elem_cnt_r == (row_len_r - LEN_W'(1)));
    end

    // One restoring-divide step; the numerator is a single 1 at bit RECI_SHIFT
    always_comb begin
        num_bit_s   = (bit_cnt_r == CNT_W'(RECI_SHIFT));
        rem_shift_s = {rem_r[REM_W-2:0], num_bit_s};
        q_bit_s     = (rem_shift_s >= {1'b0, sum_r});
        if (q_bit_s) begin
            rem_next_s = rem_shift_s - {1'b0, sum_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = {quo_r[QUO_W-2:0], q_bit_s};
        quo_ovf_s  = |quo_next_s[QUO_W-1:RECI_W];
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.row_len == LEN_W'(0)) begin
                        state_s = DONE;
                    end else begin
                        state_s = ACC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (last_s) begin
                    state_s = DIV;
                end else begin
                    state_s = ACC;
                end
            end
            DIV: begin
                if ((sum_r == SUM_W'(0)) || (bit_cnt_r == CNT_W'(0))) begin
                    state_s = DONE;
                end else begin
                    state_s = DIV;
                end
            end
            DONE: begin
                if (bus.reci_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Row sum, divider and result registers
    always_ff @(posedge core_clk) begin
        if (rst) begin
            row_len_r  <= LEN_W'(0);
            elem_cnt_r <= LEN_W'(0);
            sum_r      <= SUM_W'(0);
            rem_r      <= REM_W'(0);
            quo_r      <= QUO_W'(0);
            bit_cnt_r  <= CNT_W'(0);
            reci_r     <= RECI_W'(0);
            sat_r      <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        sum_r      <= SUM_W'(0);
                        elem_cnt_r <= LEN_W'(0);
                        if (bus.row_len == LEN_W'(0)) begin
                            reci_r <= '1;
                            sat_r  <= 1'b1;
                            zero_r <= 1'b1;
                        end else begin
                            row_len_r <= bus.row_len;
                            reci_r    <= RECI_W'(0);
                            sat_r     <= 1'b0;
                            zero_r    <= 1'b0;
                        end
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        sum_r      <= sum_r + SUM_W'(bus.din_q);
                        elem_cnt_r <= elem_cnt_r + LEN_W'(1);
                        if (last_s) begin
                            rem_r     <= REM_W'(0);
                            quo_r     <= QUO_W'(0);
                            bit_cnt_r <= CNT_W'(RECI_SHIFT);
                        end
                    end
                end
                DIV: begin
                    if (sum_r == SUM_W'(0)) begin
                        reci_r <= '1;
                        sat_r  <= 1'b1;
                        zero_r <= 1'b1;
                    end else begin
                        rem_r     <= rem_next_s;
                        quo_r     <= quo_next_s;
                        bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                        if (bit_cnt_r == CNT_W'(0)) begin
                            if (quo_ovf_s) begin
                                reci_r <= '1;
                                sat_r  <= 1'b1;
                            end else begin
                                reci_r <= quo_next_s[RECI_W-1:0];
                                sat_r  <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    reci_r <= reci_r;
                end
                default: begin
                    reci_r <= reci_r;
                end
            endcase
        end
    end

    assign bus.din_ready  = (state_r == ACC);
    assign bus.busy       = (state_r != IDLE);
    assign bus.reci_valid = (state_r == DONE);
    assign bus.sum_q      = sum_r;
    assign bus.reci_q     = reci_r;
    assign bus.reci_sat   = sat_r;
    assign bus.div_zero   = zero_r;
endmodule

// File: tb/tb_spu_sm_exp_sum_reci.sv
// Bench for spu_sm_exp_sum_reci: random rows against an arithmetic model of sum and reciprocal.
module tb_spu_sm_exp_sum_reci;
    localparam int DIN_W      = 8;
    localparam int LEN_W      = 10;
    localparam int SUM_W      = 18;
    localparam int RECI_SHIFT = 24;
    localparam int RECI_W     = 16;
    localparam int RECI_MAX   = (1 << RECI_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spu_sm_exp_sum_reci_if #(.DIN_W(DIN_W), .LEN_W(LEN_W), .SUM_W(SUM_W), .RECI_W(RECI_W)) bus ();

    spu_sm_exp_sum_reci #(
        .DIN_W(DIN_W), .LEN_W(LEN_W), .SUM_W(SUM_W), .RECI_SHIFT(RECI_SHIFT), .RECI_W(RECI_W)
    ) dut (
        .core_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          hs_cnt      = 0;
    bit          chk_en      = 1'b0;
    int unsigned vals_q[$];
    int unsigned exp_sum;
    int unsigned exp_reci;
    bit          exp_sat;
    bit          exp_dz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void model(input int unsigned s, output int unsigned r,
                                  output bit sat, output bit dz);
        longint unsigned q;
        dz = (s == 0);
        if (s == 0) begin
            r   = RECI_MAX;
            sat = 1'b1;
        end else begin
            q = (64'd1 << RECI_SHIFT) / 64'(s);
            if (q > 64'(RECI_MAX)) begin
                r   = RECI_MAX;
                sat = 1'b1;
            end else begin
                r   = 32'(q);
                sat = 1'b0;
            end
        end
    endfunction

    // Result checker: every cycle the reciprocal is offered it must equal the model
    always @(negedge clk) begin
        if (!rst && chk_en && bus.reci_valid) begin
            check("sum_q",     32'(bus.sum_q), exp_sum);
            check("reci_q",    32'(bus.reci_q), exp_reci);
            check("reci_sat",  32'(bus.reci_sat), 32'(exp_sat));
            check("div_zero",  32'(bus.div_zero), 32'(exp_dz));
            check("done_busy", 32'(bus.busy), 32'd1);
            check("done_rdy",  32'(bus.din_ready), 32'd0);
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.reci_valid && bus.reci_ready) hs_cnt++;
    end

    task automatic check_reset_vals();
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_dready", 32'(bus.din_ready), 32'd0);
        check("rst_valid",  32'(bus.reci_valid), 32'd0);
        check("rst_sat",    32'(bus.reci_sat), 32'd0);
        check("rst_dz",     32'(bus.div_zero), 32'd0);
        check("rst_sum",    32'(bus.sum_q), 32'd0);
        check("rst_reci",   32'(bus.reci_q), 32'd0);
    endtask

    task automatic run_row(input int len, input int stall, input bit hold_start, input bit noise);
        int unsigned s;
        int acc;
        int cyc;
        int n;
        int hs0;
        int exp_lat;
        bit was_acc;
        s = 0;
        foreach (vals_q[i]) s += vals_q[i];
        model(s, exp_reci, exp_sat, exp_dz);
        exp_sum = s;
        check("idle_busy", 32'(bus.busy), 32'd0);
        hs0 = hs_cnt;
        chk_en = 1'b1;
        bus.start      = 1'b1;
        bus.row_len    = LEN_W'(len);
        bus.reci_ready = (stall == 0);
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        if (len > 0) begin
            acc = 0;
            cyc = 0;
            while (acc < len && cyc < 5000) begin
                bus.din_valid = ($urandom_range(0, 3) != 0);
                bus.din_q     = bus.din_valid ? DIN_W'(vals_q[acc]) : DIN_W'($urandom);
                was_acc       = bus.din_valid && bus.din_ready;
                @(posedge clk); #1;
                cyc++;
                if (was_acc) acc++;
            end
            if (cyc >= 5000) check("acc_timeout", 32'(acc), 32'(len));
            bus.din_valid = noise;
            bus.din_q     = DIN_W'($urandom);
            check("div_dready", 32'(bus.din_ready), 32'd0);
            check("div_busy",   32'(bus.busy), 32'd1);
        end
        exp_lat = (len == 0) ? 1 : ((s == 0) ? 2 : RECI_SHIFT + 2);
        n = 0;
        while (!bus.reci_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n + 1), 32'(exp_lat));
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.reci_valid), 32'd1);
            bus.reci_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.din_valid  = 1'b0;
        bus.reci_ready = 1'b0;
        check("post_valid", 32'(bus.reci_valid), 32'd0);
        check("post_busy",  32'(bus.busy), 32'd0);
        check("handshakes", 32'(hs_cnt - hs0), 32'd1);
        chk_en = 1'b0;
    endtask

    initial begin
        int unsigned r;
        bit sat;
        bit dz;
        int len;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.row_len    = LEN_W'(0);
        bus.din_valid  = 1'b0;
        bus.din_q      = DIN_W'(0);
        bus.reci_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        // Hand-computed anchors for the model
        model(1020, r, sat, dz); check("pin_1020", r, 32'd16448); check("pin_1020_sat", 32'(sat), 32'd0);
        model(257, r, sat, dz);  check("pin_257", r, 32'd65280);
        model(256, r, sat, dz);  check("pin_256_sat", 32'(sat), 32'd1);
        model(0, r, sat, dz);    check("pin_0_dz", 32'(dz), 32'd1);

        vals_q = {255, 255, 255, 255}; run_row(4, 0, 1'b0, 1'b0);
        vals_q = {1};                  run_row(1, 0, 1'b0, 1'b0);
        vals_q = {128, 128};           run_row(2, 0, 1'b0, 1'b0);
        vals_q = {255, 2};             run_row(2, 0, 1'b0, 1'b0);
        vals_q = {0, 0, 0};            run_row(3, 0, 1'b0, 1'b0);
        vals_q = {};                   run_row(0, 2, 1'b0, 1'b0);
        vals_q = {200, 17, 255, 90, 3, 180}; run_row(6, 10, 1'b0, 1'b0);

        // Abort mid-accumulate (2 of 4 accepted)
        bus.start = 1'b1; bus.row_len = LEN_W'(4);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.din_valid = 1'b1; bus.din_q = DIN_W'(50);
        repeat (2) @(posedge clk);
        #1;
        bus.din_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();

        // Abort mid-divide
        bus.start = 1'b1; bus.row_len = LEN_W'(2);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.din_valid = 1'b1; bus.din_q = DIN_W'(99);
        repeat (2) @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();
        vals_q = {100, 150, 7}; run_row(3, 1, 1'b0, 1'b0);

        vals_q = {40, 250, 33, 128, 77}; run_row(5, 3, 1'b1, 1'b1);

        vals_q = {};
        for (int i = 0; i < 1023; i++) vals_q.push_back(255);
        run_row(1023, 0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            len = $urandom_range(1, 12);
            vals_q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) vals_q.push_back(0);
                else vals_q.push_back($urandom_range(0, 255));
            end
            run_row(len, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
